udatapath_pipe: RTL and testbench
=================================

UDATAPATH_PIPE -- requirements
Module: udatapath_pipe

Interface
REQ-001 SHALL have parameter DATAWIDTH_BUS, default 32, data/register width; power of two, 8..64.
REQ-002 SHALL have parameter DATAWIDTH_REGSEL, default 3, register-select width; register count NUM_REGS = 2**DATAWIDTH_REGSEL.
REQ-003 SHALL have parameter DATAWIDTH_ALU_SELECTION, default 4, ALU opcode width.
REQ-004 SHALL have parameter DATA_REGFIXED_INIT_0, default 0, constant value of read-only register R0.
REQ-005 SHALL have ports: UDATAPATH_PIPE_CLOCK_50  in  1  single clock, rising edge.
REQ-006 UDATAPATH_PIPE_Reset_InLow  in  1  reset; one clock, reset asynchronous and active-low.
REQ-007 UDATAPATH_PIPE_InstrValid_In  in  1  instruction offered.
REQ-008 UDATAPATH_PIPE_InstrReady_Out  out  1  instruction accepted when Valid and Ready both high at a rising edge.
REQ-009 UDATAPATH_PIPE_SelA_In, _SelB_In, _SelC_In  in  DATAWIDTH_REGSEL each  bus A source, bus B source, bus C destination.
REQ-010 UDATAPATH_PIPE_AluOp_In  in  DATAWIDTH_ALU_SELECTION  operation.
REQ-011 UDATAPATH_PIPE_WrEn_In  in  1  write result to SelC.
REQ-012 UDATAPATH_PIPE_ResultValid_Out  out  1  one-cycle completion pulse.
REQ-013 UDATAPATH_PIPE_DataBUSDisplay_Out  out  DATAWIDTH_BUS  last completed bus C result.
REQ-014 UDATAPATH_PIPE_Flags_Out  out  4  {N,Z,C,V} of last completed op.

Function
REQ-015 At accept edge, SHALL latch bus A/B operands, opcode, SelC, WrEn into EX registers; reads of R0 SHALL return DATA_REGFIXED_INIT_0.
REQ-016 Bypass: if EX stage completes a write (WrEn, SelC!=0) in the cycle an instruction is accepted and SelC equals SelA/SelB, SHALL latch that result instead of the stale register.
REQ-017 Opcodes: 0 PASSA, 1 ADD, 2 SUB (A-B), 3 AND, 4 OR, 5 XOR, 6 NOT A, 7 SHL1, 8 SHR1 logical, 9 SHLN, 10 SHRN logical, 11 INC A; 12-15 SHALL behave as PASSA.
REQ-018 SHLN/SHRN: count n = B[log2(DATAWIDTH_BUS)-1:0]; shift one bit per cycle; EX occupies max(1,n) cycles; n=0 gives result A.
REQ-019 Single-cycle ops SHALL occupy exactly one EX cycle.
REQ-020 State machine: IDLE (no op in EX) -> EXEC on accept; EXEC -> EXEC on accept in final EX cycle; EXEC -> IDLE on final cycle without accept.
REQ-021 InstrReady SHALL be high in IDLE and in the final EX cycle; low in non-final cycles of SHLN/SHRN.
REQ-022 Writeback at the edge ending the final EX cycle; writes to R0 SHALL be ignored; WrEn=0 SHALL update display/flags only.
REQ-023 ResultValid, DataBUSDisplay, Flags SHALL update together, registered, in the cycle after that edge; latency accept-edge to ResultValid = max(1,n)+1 cycles.
REQ-024 Flags: Z = result==0, N = result MSB; ADD: C carry-out, V signed overflow; SUB: C = no-borrow (A>=B unsigned), V signed overflow; INC as ADD with B=1; shifts: C = last bit out (0 when n=0), V=0; others C=V=0.
REQ-025 Arithmetic SHALL wrap modulo 2**DATAWIDTH_BUS.
REQ-026 Back-to-back single-cycle instructions SHALL sustain one accept per cycle.

Reset
REQ-027 On Reset_InLow low, immediately and independent of clock: R1..R(NUM_REGS-1)=0, state IDLE, InstrReady=1, ResultValid=0, DataBUSDisplay=0, Flags=0.
REQ-028 Reset during an in-flight op SHALL abort it with no register write and no ResultValid pulse.
REQ-029 First accept SHALL be possible at the first rising edge after Reset_InLow deasserts.

Verification
REQ-030 Reset, then INC R1<=R0 x3 with DATA_REGFIXED_INIT_0=0 back-to-back -> bypass used; ResultValid 3 consecutive cycles; display 1,2,3; R1=3.
REQ-031 R1=0x7FFFFFFF, R2=1, ADD R3<=R1+R2 -> display 0x80000000, Flags N=1,Z=0,C=0,V=1.
REQ-032 R1=5, R2=5, SUB R3 -> display 0, Z=1, C=1, V=0; then SUB R4<=R0-R2 -> 0xFFFFFFFB, C=0, N=1.
REQ-033 R1=0x80000001, R2=4, SHLN -> Ready low 3 cycles, ResultValid 5 cycles after accept, display 0x00000010, C=0; SHRN with R2=0 -> one EX cycle, display 0x80000001.
REQ-034 Write to R0 then read R0 -> DATA_REGFIXED_INIT_0 returned; assert Reset_InLow mid-SHLN -> outputs cleared same cycle, destination unchanged, no ResultValid.

Source files
------------

// File: rtl/udatapath_pipe_if.sv
// Instruction/result handshake bundle for udatapath_pipe.
// The master drives instructions and the slave (the datapath) returns results.
`timescale 1ns/1ps
interface udatapath_pipe_if #(
    parameter int DATAWIDTH_BUS           = 32,
    parameter int DATAWIDTH_REGSEL        = 3,
    parameter int DATAWIDTH_ALU_SELECTION = 4
);
    logic                               UDATAPATH_PIPE_InstrValid_In;
    logic                               UDATAPATH_PIPE_InstrReady_Out;
    logic [DATAWIDTH_REGSEL-1:0]        UDATAPATH_PIPE_SelA_In;
    logic [DATAWIDTH_REGSEL-1:0]        UDATAPATH_PIPE_SelB_In;
    logic [DATAWIDTH_REGSEL-1:0]        UDATAPATH_PIPE_SelC_In;
    logic [DATAWIDTH_ALU_SELECTION-1:0] UDATAPATH_PIPE_AluOp_In;
    logic                               UDATAPATH_PIPE_WrEn_In;
    logic                               UDATAPATH_PIPE_ResultValid_Out;
    logic [DATAWIDTH_BUS-1:0]           UDATAPATH_PIPE_DataBUSDisplay_Out;
    logic [3:0]                         UDATAPATH_PIPE_Flags_Out;

    modport master (
        output UDATAPATH_PIPE_InstrValid_In, UDATAPATH_PIPE_SelA_In, UDATAPATH_PIPE_SelB_In,
               UDATAPATH_PIPE_SelC_In, UDATAPATH_PIPE_AluOp_In, UDATAPATH_PIPE_WrEn_In,
        input  UDATAPATH_PIPE_InstrReady_Out, UDATAPATH_PIPE_ResultValid_Out,
               UDATAPATH_PIPE_DataBUSDisplay_Out, UDATAPATH_PIPE_Flags_Out
    );

    modport slave (
        input  UDATAPATH_PIPE_InstrValid_In, UDATAPATH_PIPE_SelA_In, UDATAPATH_PIPE_SelB_In,
               UDATAPATH_PIPE_SelC_In, UDATAPATH_PIPE_AluOp_In, UDATAPATH_PIPE_WrEn_In,
        output UDATAPATH_PIPE_InstrReady_Out, UDATAPATH_PIPE_ResultValid_Out,
               UDATAPATH_PIPE_DataBUSDisplay_Out, UDATAPATH_PIPE_Flags_Out
    );
endinterface

// File: rtl/udatapath_pipe.sv
// Two-stage micro-datapath: register-file read/bypass at accept, one EX stage
// (multi-cycle for SHLN/SHRN, one bit per cycle), writeback plus a registered
// result/flags display. R0 is read-only and reads as DATA_REGFIXED_INIT_0.
`timescale 1ns/1ps
module udatapath_pipe #(
    parameter int                       DATAWIDTH_BUS           = 32,
    parameter int                       DATAWIDTH_REGSEL        = 3,
    parameter int                       DATAWIDTH_ALU_SELECTION = 4,
    parameter logic [DATAWIDTH_BUS-1:0] DATA_REGFIXED_INIT_0    = '0
) (
    input  logic                  UDATAPATH_PIPE_CLOCK_50,
    input  logic                  UDATAPATH_PIPE_Reset_InLow,
    udatapath_pipe_if.slave       bus
);
    localparam int W        = DATAWIDTH_BUS;
    localparam int NUM_REGS = 2 ** DATAWIDTH_REGSEL;
    localparam int SHW      = $clog2(DATAWIDTH_BUS);
    localparam int OPW      = DATAWIDTH_ALU_SELECTION;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(1);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(2);
    localparam logic [OPW-1:0] OP_AND  = OPW'(3);
    localparam logic [OPW-1:0] OP_OR   = OPW'(4);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(5);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(6);
    localparam logic [OPW-1:0] OP_SHL1 = OPW'(7);
    localparam logic [OPW-1:0] OP_SHR1 = OPW'(8);
    localparam logic [OPW-1:0] OP_SHLN = OPW'(9);
    localparam logic [OPW-1:0] OP_SHRN = OPW'(10);
    localparam logic [OPW-1:0] OP_INC  = OPW'(11);

    typedef enum logic {S_IDLE, S_EXEC} state_t;

    logic clk, rst_n;
    assign clk   = UDATAPATH_PIPE_CLOCK_50;
    assign rst_n = UDATAPATH_PIPE_Reset_InLow;

    state_t                   state_q, state_d;
    logic [W-1:0]             a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [OPW-1:0]           op_q, op_d;
    logic [DATAWIDTH_REGSEL-1:0] selc_q, selc_d;
    logic                     wren_q, wren_d;
    logic [SHW-1:0]           cnt_q, cnt_d;
    logic [W-1:0]             regs_q [NUM_REGS];
    logic [W-1:0]             regs_d [NUM_REGS];
    logic                     rv_q, rv_d;
    logic [W-1:0]             disp_q, disp_d;
    logic [3:0]               flags_q, flags_d;

    logic [W-1:0] alu_res, shl_step, shr_step, rd_a, rd_b;
    logic [W:0]   sum_ext;
    logic         alu_c, alu_v, is_shn, final_cycle, ready, accept, wb_en;

    // Handshake and writeback qualifiers; only SHLN/SHRN with count > 1 hold the EX stage.
    always_comb begin
        is_shn      = (op_q == OP_SHLN) || (op_q == OP_SHRN);
        final_cycle = (state_q == S_EXEC) && !(is_shn && (cnt_q > SHW'(1)));
        ready       = (state_q == S_IDLE) || final_cycle;
        accept      = bus.UDATAPATH_PIPE_InstrValid_In && ready;
        wb_en       = final_cycle && wren_q && (selc_q != '0);
    end

    // Operand read with R0 fixed and a bypass from the result being written this edge.
    always_comb begin
        rd_a = (bus.UDATAPATH_PIPE_SelA_In == '0) ? DATA_REGFIXED_INIT_0
                                                  : regs_q[bus.UDATAPATH_PIPE_SelA_In];
        rd_b = (bus.UDATAPATH_PIPE_SelB_In == '0) ? DATA_REGFIXED_INIT_0
                                                  : regs_q[bus.UDATAPATH_PIPE_SelB_In];
        if (wb_en && (selc_q == bus.UDATAPATH_PIPE_SelA_In)) rd_a = alu_res;
        if (wb_en && (selc_q == bus.UDATAPATH_PIPE_SelB_In)) rd_b = alu_res;
    end

    // ALU: result and carry/overflow for the op currently in EX.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value held (no latch).
        alu_res  = a_q;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        sum_ext  = '0;
        shl_step = {acc_q[W-2:0], 1'b0};
        shr_step = {1'b0, acc_q[W-1:1]};
        case (op_q)
            OP_ADD: begin
                sum_ext = {1'b0, a_q} + {1'b0, b_q};
                alu_res = sum_ext[W-1:0];
                alu_c   = sum_ext[W];
                alu_v   = (a_q[W-1] == b_q[W-1]) && (alu_res[W-1] != a_q[W-1]);
            end
            OP_SUB: begin
                alu_res = a_q - b_q;
                alu_c   = (a_q >= b_q);
                alu_v   = (a_q[W-1] != b_q[W-1]) && (alu_res[W-1] != a_q[W-1]);
            end
            OP_INC: begin
                sum_ext = {1'b0, a_q} + {{W{1'b0}}, 1'b1};
                alu_res = sum_ext[W-1:0];
                alu_c   = sum_ext[W];
                alu_v   = !a_q[W-1] && alu_res[W-1];
            end
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_NOT:  alu_res = ~a_q;
            OP_SHL1: begin
                alu_res = {a_q[W-2:0], 1'b0};
                alu_c   = a_q[W-1];
            end
            OP_SHR1: begin
                alu_res = {1'b0, a_q[W-1:1]};
                alu_c   = a_q[0];
            end
            OP_SHLN: begin
                alu_res = (cnt_q == '0) ? acc_q : shl_step;
                alu_c   = (cnt_q != '0) && acc_q[W-1];
            end
            OP_SHRN: begin
                alu_res = (cnt_q == '0) ? acc_q : shr_step;
                alu_c   = (cnt_q != '0) && acc_q[0];
            end
            default: alu_res = a_q;
        endcase
    end

    // Next-state: shift stepping, completion/writeback, then a new accept overrides EX fields.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        op_d    = op_q;
        selc_d  = selc_q;
        wren_d  = wren_q;
        cnt_d   = cnt_q;
        regs_d  = regs_q;
        rv_d    = 1'b0;
        disp_d  = disp_q;
        flags_d = flags_q;
        if ((state_q == S_EXEC) && !final_cycle) begin
            acc_d = (op_q == OP_SHLN) ? shl_step : shr_step;
            cnt_d = cnt_q - 1'b1;
        end
        if (final_cycle) begin
            state_d = S_IDLE;
            rv_d    = 1'b1;
            disp_d  = alu_res;
            flags_d = {alu_res[W-1], (alu_res == '0), alu_c, alu_v};
            if (wb_en) regs_d[selc_q] = alu_res;
        end
        if (accept) begin
            state_d = S_EXEC;
            a_d     = rd_a;
            b_d     = rd_b;
            acc_d   = rd_a;
            cnt_d   = rd_b[SHW-1:0];
            op_d    = bus.UDATAPATH_PIPE_AluOp_In;
            selc_d  = bus.UDATAPATH_PIPE_SelC_In;
            wren_d  = bus.UDATAPATH_PIPE_WrEn_In;
        end
    end

    // State registers; reset aborts any in-flight op and clears visible outputs at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            op_q    <= '0;
            selc_q  <= '0;
            wren_q  <= 1'b0;
            cnt_q   <= '0;
            rv_q    <= 1'b0;
            disp_q  <= '0;
            flags_q <= '0;
            // NOTE: the register file is cleared by the async reset, so it must stay in flops.
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            // NOTE: non-blocking so each flop takes its pre-edge _d value regardless of order.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            selc_q  <= selc_d;
            wren_q  <= wren_d;
            cnt_q   <= cnt_d;
            regs_q  <= regs_d;
            rv_q    <= rv_d;
            disp_q  <= disp_d;
            flags_q <= flags_d;
        end
    end

    assign bus.UDATAPATH_PIPE_InstrReady_Out     = ready;
    assign bus.UDATAPATH_PIPE_ResultValid_Out    = rv_q;
    assign bus.UDATAPATH_PIPE_DataBUSDisplay_Out = disp_q;
    assign bus.UDATAPATH_PIPE_Flags_Out          = flags_q;
endmodule

// File: tb/tb_udatapath_pipe.sv
// Self-checking bench for udatapath_pipe: a reference model predicts each
// result/flags/completion cycle at accept time and a monitor compares on ResultValid.
`timescale 1ns/1ps
module tb_udatapath_pipe;
    localparam logic [31:0] FIX = 32'h0;
    localparam logic [3:0] OP_PASSA = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3,
                           OP_OR = 4'd4, OP_XOR = 4'd5, OP_NOT = 4'd6, OP_SHL1 = 4'd7,
                           OP_SHR1 = 4'd8, OP_SHLN = 4'd9, OP_SHRN = 4'd10, OP_INC = 4'd11;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        exp_q [$];
    logic [31:0] mregs [8];

    udatapath_pipe_if bus ();

    udatapath_pipe dut (
        .UDATAPATH_PIPE_CLOCK_50    (clk),
        .UDATAPATH_PIPE_Reset_InLow (rst_n),
        .bus                        (bus.slave)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [2:0] s);
        return (s == 3'd0) ? FIX : mregs[s];
    endfunction

    // Reference: returns {result, N, Z, C, V}.
    function automatic logic [35:0] model_exec(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [31:0]     r;
        logic            c, v;
        int              n;
        longint          sa, sb, ss;
        longint unsigned us;
        r = a; c = 1'b0; v = 1'b0; n = int'(b[4:0]);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_ADD: begin
                us = longint'(a) + longint'(b); r = us[31:0]; c = (us > 64'hFFFF_FFFF);
                ss = sa + sb; v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            OP_SUB: begin
                r = a - b; c = (a >= b);
                ss = sa - sb; v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            OP_INC: begin
                us = longint'(a) + 64'd1; r = us[31:0]; c = (us > 64'hFFFF_FFFF);
                ss = sa + 64'sd1; v = (ss > 64'sd2147483647);
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOT:  r = ~a;
            OP_SHL1: begin r = a << 1; c = a[31]; end
            OP_SHR1: begin r = a >> 1; c = a[0]; end
            OP_SHLN: begin r = a << n; c = (n == 0) ? 1'b0 : a[32-n]; end
            OP_SHRN: begin r = a >> n; c = (n == 0) ? 1'b0 : a[n-1]; end
            default: r = a;
        endcase
        return {r, r[31], (r == 32'd0), c, v};
    endfunction

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic issue(input logic [3:0] op, input logic [2:0] sa, input logic [2:0] sb,
                         input logic [2:0] sc, input logic we);
        int          guard;
        int          n;
        logic [31:0] a, b;
        logic [35:0] m;
        exp_t        e;
        bus.UDATAPATH_PIPE_InstrValid_In = 1'b1;
        bus.UDATAPATH_PIPE_AluOp_In      = op;
        bus.UDATAPATH_PIPE_SelA_In       = sa;
        bus.UDATAPATH_PIPE_SelB_In       = sb;
        bus.UDATAPATH_PIPE_SelC_In       = sc;
        bus.UDATAPATH_PIPE_WrEn_In       = we;
        guard = 0;
        while (bus.UDATAPATH_PIPE_InstrReady_Out !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("ready_timeout", 64'(bus.UDATAPATH_PIPE_InstrReady_Out), 64'd1);
        a = rd(sa);
        b = rd(sb);
        m = model_exec(op, a, b);
        if (we && sc != 3'd0) mregs[sc] = m[35:4];
        n = ((op == OP_SHLN) || (op == OP_SHRN)) ? int'(b[4:0]) : 1;
        if (n == 0) n = 1;
        e.res   = m[35:4];
        e.flags = m[3:0];
        e.cyc   = cyc + 1 + n;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.UDATAPATH_PIPE_InstrValid_In = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        idle();
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) mregs[i] = 32'd0;
        exp_q.delete();
    endtask

    // Scoreboard monitor: every ResultValid must match the oldest prediction, in its cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && bus.UDATAPATH_PIPE_ResultValid_Out === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_result_valid", 64'(bus.UDATAPATH_PIPE_ResultValid_Out), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", 64'(bus.UDATAPATH_PIPE_DataBUSDisplay_Out), 64'(e.res));
                check("sb_flags", 64'(bus.UDATAPATH_PIPE_Flags_Out), 64'(e.flags));
                check("sb_latency_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n_low;
        logic [3:0]  rop;
        logic [2:0]  ra, rb, rc;
        clear_model();
        idle();
        bus.UDATAPATH_PIPE_AluOp_In = '0;
        bus.UDATAPATH_PIPE_SelA_In  = '0;
        bus.UDATAPATH_PIPE_SelB_In  = '0;
        bus.UDATAPATH_PIPE_SelC_In  = '0;
        bus.UDATAPATH_PIPE_WrEn_In  = 1'b0;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #2;
        check("rst_ready", 64'(bus.UDATAPATH_PIPE_InstrReady_Out), 64'd1);
        check("rst_rv", 64'(bus.UDATAPATH_PIPE_ResultValid_Out), 64'd0);
        check("rst_disp", 64'(bus.UDATAPATH_PIPE_DataBUSDisplay_Out), 64'd0);
        check("rst_flags", 64'(bus.UDATAPATH_PIPE_Flags_Out), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back INC R1 chain through the bypass; first accept on first edge after reset.
        issue(OP_INC, 3'd0, 3'd0, 3'd1, 1'b1);
        issue(OP_INC, 3'd1, 3'd0, 3'd1, 1'b1);
        issue(OP_INC, 3'd1, 3'd0, 3'd1, 1'b1);
        wait_drain();
        check("inc3_disp", 64'(bus.UDATAPATH_PIPE_DataBUSDisplay_Out), 64'd3);
        issue(OP_PASSA, 3'd1, 3'd0, 3'd6, 1'b1);
        wait_drain();
        check("inc3_r1", 64'(bus.UDATAPATH_PIPE_DataBUSDisplay_Out), 64'd3);

        // Signed overflow on ADD: 0x7FFFFFFF + 1.
        issue(OP_NOT,  3'd0, 3'd0, 3'd1, 1'b1);
        issue(OP_SHR1, 3'd1, 3'd0, 3'd1, 1'b1);
        issue(OP_INC,  3'd0, 3'd0, 3'd2, 1'b1);
        issue(OP_ADD,  3'd1, 3'd2, 3'd3, 1'b1);
        wait_drain();
        check("add_ovf_disp", 64'(bus.UDATAPATH_PIPE_DataBUSDisplay_Out), 64'h8000_0000);
        check("add_ovf_flags", 64'(bus.UDATAPATH_PIPE_Flags_Out), 64'b1001);

        // SUB equal operands, then borrow.
        issue(OP_INC, 3'd0, 3'd0, 3'd1, 1'b1);
        for (int i = 0; i < 4; i++) issue(OP_INC, 3'd1, 3'd0, 3'd1, 1'b1);
        issue(OP_PASSA, 3'd1, 3'd0, 3'd2, 1'b1);
        issue(OP_SUB, 3'd1, 3'd2, 3'd3, 1'b1);
        wait_drain();
        check("sub_eq_disp", 64'(bus.UDATAPATH_PIPE_DataBUSDisplay_Out), 64'd0);
        check("sub_eq_flags", 64'(bus.UDATAPATH_PIPE_Flags_Out), 64'b0110);
        issue(OP_SUB, 3'd0, 3'd2, 3'd4, 1'b1);
        wait_drain();
        check("sub_borrow_disp", 64'(bus.UDATAPATH_PIPE_DataBUSDisplay_Out), 64'hFFFF_FFFB);
        check("sub_borrow_flags", 64'(bus.UDATAPATH_PIPE_Flags_Out), 64'b1000);

        // Write to R0 is ignored; R0 reads the fixed constant.
        issue(OP_ADD, 3'd1, 3'd2, 3'd0, 1'b1);
        issue(OP_PASSA, 3'd0, 3'd0, 3'd3, 1'b1);
        wait_drain();
        check("r0_fixed", 64'(bus.UDATAPATH_PIPE_DataBUSDisplay_Out), 64'(FIX));

        // Multi-cycle SHLN by 4 on 0x80000001, then SHRN by 0.
        issue(OP_INC,  3'd0, 3'd0, 3'd1, 1'b1);
        issue(OP_NOT,  3'd0, 3'd0, 3'd4, 1'b1);
        issue(OP_SHR1, 3'd4, 3'd0, 3'd4, 1'b1);
        issue(OP_NOT,  3'd4, 3'd0, 3'd4, 1'b1);
        issue(OP_OR,   3'd4, 3'd1, 3'd1, 1'b1);
        issue(OP_INC,  3'd0, 3'd0, 3'd2, 1'b1);
        issue(OP_SHL1, 3'd2, 3'd0, 3'd2, 1'b1);
        issue(OP_SHL1, 3'd2, 3'd0, 3'd2, 1'b1);
        issue(OP_SHLN, 3'd1, 3'd2, 3'd3, 1'b1);
        idle();
        n_low = 0;
        while (bus.UDATAPATH_PIPE_InstrReady_Out !== 1'b1 && n_low < 50) begin
            n_low++;
            @(negedge clk);
        end
        check("shln_ready_low_cycles", 64'(n_low), 64'd3);
        wait_drain();
        check("shln_disp", 64'(bus.UDATAPATH_PIPE_DataBUSDisplay_Out), 64'h10);
        check("shln_flags", 64'(bus.UDATAPATH_PIPE_Flags_Out), 64'b0000);
        issue(OP_SHRN, 3'd1, 3'd0, 3'd3, 1'b1);
        wait_drain();
        check("shrn0_disp", 64'(bus.UDATAPATH_PIPE_DataBUSDisplay_Out), 64'h8000_0001);
        check("shrn0_flags", 64'(bus.UDATAPATH_PIPE_Flags_Out), 64'b1000);

        // Random mix, checked entirely by the scoreboard.
        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = 3'($urandom_range(0, 7));
            rb  = 3'($urandom_range(0, 7));
            rc  = 3'($urandom_range(0, 7));
            issue(rop, ra, rb, rc, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle();
        end
        wait_drain();

        // Reset in the middle of a 31-cycle SHLN.
        issue(OP_NOT, 3'd0, 3'd0, 3'd2, 1'b1);
        issue(OP_SHLN, 3'd1, 3'd2, 3'd5, 1'b1);
        idle();
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        clear_model();
        #1;
        check("abort_ready", 64'(bus.UDATAPATH_PIPE_InstrReady_Out), 64'd1);
        check("abort_rv", 64'(bus.UDATAPATH_PIPE_ResultValid_Out), 64'd0);
        check("abort_disp", 64'(bus.UDATAPATH_PIPE_DataBUSDisplay_Out), 64'd0);
        check("abort_flags", 64'(bus.UDATAPATH_PIPE_Flags_Out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(OP_PASSA, 3'd5, 3'd0, 3'd6, 1'b1);
        wait_drain();
        check("abort_dest_unchanged", 64'(bus.UDATAPATH_PIPE_DataBUSDisplay_Out), 64'd0);
        check("queue_empty_at_end", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
